// File: rtl/csa_pkg.sv
// Shared defaults and state encoding for the carry-save accumulator.
package csa_pkg;

  localparam int unsigned CSA_WIDTH = 88;
  localparam int unsigned CSA_DIGIT = 22;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

endpackage

// File: rtl/csa_row.sv
// One row of W independent full-adder cells (3:2 compressor); no carry ripple.
module csa_row #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic [W-1:0] Z,
  output logic [W-1:0] S,
  output logic [W-1:0] C
);

  assign S = X ^ Y ^ Z;
  assign C = (X & Y) | (X & Z) | (Y & Z);

endmodule

// File: rtl/csa_accum.sv
// Packet accumulator: carry-save sum per beat, then DIGIT-wide carry resolve.
module csa_accum
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH,
  parameter int unsigned DIGIT = CSA_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] s_q, cs_q, res_q;
  logic [WIDTH-1:0] x_op, y_op, row_s, row_c, res_next;
  logic [CW-1:0]    dig_q;
  logic             carry_q, ovf_q;
  logic             accept, last_dig;
  logic [DIGIT:0]   slice_sum;

  assign accept   = in_valid & in_ready;
  assign last_dig = (dig_q == CW'(NDIG - 1));
  assign x_op     = (state == IDLE) ? '0 : s_q;
  assign y_op     = (state == IDLE) ? '0 : cs_q;

  csa_row #(.W(WIDTH)) u_row (
    .X (x_op),
    .Y (y_op),
    .Z (in_data),
    .S (row_s),
    .C (row_c)
  );

  // S/Cs shift right during resolve so the low slice is always the one added;
  // the result fills in from the top and is fully aligned after NDIG slices.
  always_comb begin
    slice_sum = {1'b0, s_q[DIGIT-1:0]} + {1'b0, cs_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    res_next  = res_q >> DIGIT;
    res_next[WIDTH-1 -: DIGIT] = slice_sum[DIGIT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_last ? RESOLVE : ACCUM;
      end
      RESOLVE: begin
        if (last_dig) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      cs_q    <= '0;
      res_q   <= '0;
      dig_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            s_q     <= row_s;
            cs_q    <= row_c << 1;
            ovf_q   <= ovf_q | row_c[WIDTH-1];
            carry_q <= 1'b0;
            dig_q   <= '0;
          end
        end
        RESOLVE: begin
          s_q     <= s_q >> DIGIT;
          cs_q    <= cs_q >> DIGIT;
          res_q   <= res_next;
          carry_q <= slice_sum[DIGIT];
          dig_q   <= dig_q + 1'b1;
          if (last_dig && slice_sum[DIGIT]) ovf_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            s_q   <= '0;
            cs_q  <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = res_q;
  assign out_ovf  = ovf_q;

endmodule
